// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage and the main decoder.
package fetch_pkg;

  // addi x0, x0, 0: the architecturally harmless filler for empty slots
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Major opcodes, also consumed by the main decoder
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // S_FETCH: a request is being issued or is outstanding.
  // S_HOLD:  a valid instruction is stalled; no request goes out.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register: sync reset, redirect load, and +4 increment.
module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Wraps modulo 2^XLEN; no alignment trap exists in this stage.
  assign pc_plus4_o = pc_q + XLEN'(4);
  assign pc_o       = pc_q;

  // Next PC: a redirect load outranks the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_plus4_o;
    end
  end

  // PC state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives imem over req/ready, holds the fetched
// instruction for the decoder, honours downstream stall and PC redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            instr_valid
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  fetch_state_e    state_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_hold_q;
  logic [XLEN-1:0] pc_plus4_hold_q;
  logic            valid_q;

  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_cur_plus4;
  logic            redirect;
  logic            stall_hold;
  logic            fetch_fire;

  // A redirect only counts when it refers to a live instruction.
  assign redirect   = PCSrc && valid_q;
  // A stall with nothing held is meaningless and is ignored.
  assign stall_hold = valid_q && stall;
  assign imem_req   = !reset && (state_q == S_FETCH) && !redirect;
  // A response arriving in the first stall cycle is dropped; the request is
  // withdrawn next cycle, which memory treats as an abort.
  assign fetch_fire = imem_req && imem_ready && !stall_hold;

  assign imem_addr   = pc_cur & WORD_MASK;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign PC          = pc_hold_q;
  assign PCPlus4     = pc_plus4_hold_q;
  assign instr_valid = valid_q;

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .load_i      (redirect),
    .load_addr_i (PCTarget & WORD_MASK),
    .inc_i       (fetch_fire),
    .pc_o        (pc_cur),
    .pc_plus4_o  (pc_cur_plus4)
  );

  // Output register and FSM, resolved in priority: reset, redirect, stall, fetch, consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_FETCH;
      instr_q         <= NOP_INSTR;
      pc_hold_q       <= '0;
      pc_plus4_hold_q <= XLEN'(4);
      valid_q         <= 1'b0;
    end else if (redirect) begin
      state_q <= S_FETCH;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (stall_hold) begin
      state_q <= S_HOLD;
    end else if (fetch_fire) begin
      state_q         <= S_FETCH;
      instr_q         <= imem_rdata;
      pc_hold_q       <= pc_cur;
      pc_plus4_hold_q <= pc_cur_plus4;
      valid_q         <= 1'b1;
    end else begin
      state_q <= S_FETCH;
      if (valid_q) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a cycle-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .instr       (instr),
    .op          (op),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the stage.
  // m_stalled_last means the previous cycle was a stall of a live instruction,
  // so no request may go out this cycle.
  logic [31:0] m_pc, m_instr, m_hold_pc, m_hold_pc4;
  bit          m_valid, m_stalled_last, model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_instr = NOP; m_hold_pc = 32'h0; m_hold_pc4 = 32'h4;
      m_valid = 0; m_stalled_last = 0; model_ok = 1;
    end else if (PCSrc && m_valid) begin
      m_pc = {PCTarget[31:2], 2'b00};
      m_valid = 0; m_instr = NOP; m_stalled_last = 0;
    end else if (m_valid && stall) begin
      m_stalled_last = 1;
    end else begin
      if (!m_stalled_last && imem_ready) begin
        m_instr = imem_rdata; m_hold_pc = m_pc; m_hold_pc4 = m_pc + 32'd4;
        m_valid = 1; m_pc = m_pc + 32'd4;
      end else if (m_valid) begin
        m_valid = 0; m_instr = NOP;
      end
      m_stalled_last = 0;
    end
  end

  // Compare process: all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      check("imem_req", 32'(imem_req), 32'(!reset && !m_stalled_last && !(PCSrc && m_valid)));
      if (!reset) begin
        check("imem_addr",   imem_addr,          m_pc);
        check("instr",       instr,              m_instr);
        check("op",          32'(op),            32'(m_instr[6:0]));
        check("instr_valid", 32'(instr_valid),   32'(m_valid));
        check("PC",          PC,                 m_hold_pc);
        check("PCPlus4",     PCPlus4,            m_hold_pc4);
      end
    end
  end

  task automatic step(input logic rst, input logic rdy, input logic [31:0] rdata,
                      input logic stl, input logic src, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset = rst; imem_ready = rdy; imem_rdata = rdata;
    stall = stl; PCSrc = src; PCTarget = tgt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    stall = 1'b0; PCSrc = 1'b0; PCTarget = '0;

    // reset held
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h1111_1111, 0, 0, 0);
    check("lit reset req", 32'(imem_req), 32'h0);

    // zero-wait fetch of 0x00500093 at address 0
    step(0, 1, 32'h0050_0093, 0, 0, 0);
    check("lit c1 req",  32'(imem_req), 32'h1);
    check("lit c1 addr", imem_addr, 32'h0);
    check("lit c1 nop",  instr, NOP);

    // two wait states at address 4
    step(0, 0, 0, 0, 0, 0);
    check("lit f0 valid", 32'(instr_valid), 32'h1);
    check("lit f0 instr", instr, 32'h0050_0093);
    check("lit f0 op",    32'(op), 32'h13);
    check("lit f0 PC",    PC, 32'h0);
    check("lit f0 PC4",   PCPlus4, 32'h4);
    check("lit f0 addr",  imem_addr, 32'h4);
    step(0, 0, 0, 0, 0, 0);
    check("lit w2 addr",  imem_addr, 32'h4);
    check("lit w2 valid", 32'(instr_valid), 32'h0);
    check("lit w2 instr", instr, NOP);
    step(0, 1, 32'h00A0_0113, 0, 0, 0);
    check("lit w3 addr", imem_addr, 32'h4);
    check("lit w3 req",  32'(imem_req), 32'h1);

    // fetch at 8, then stall it for three cycles
    step(0, 1, 32'h00C0_0193, 0, 0, 0);
    step(0, 1, 32'hBAD0_0001, 1, 0, 0);
    check("lit st1 PC", PC, 32'h8);
    step(0, 0, 0, 1, 0, 0);
    check("lit st2 req",   32'(imem_req), 32'h0);
    check("lit st2 instr", instr, 32'h00C0_0193);
    step(0, 0, 0, 1, 0, 0);
    check("lit st3 req", 32'(imem_req), 32'h0);
    check("lit st3 PC",  PC, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0463, 0, 0, 0);
    check("lit resume req",  32'(imem_req), 32'h1);
    check("lit resume addr", imem_addr, 32'hC);

    // redirect to 0x40 with a coincident response that must be dropped
    step(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h40);
    step(0, 1, 32'h0140_006F, 0, 0, 0);
    check("lit rd valid", 32'(instr_valid), 32'h0);
    check("lit rd addr",  imem_addr, 32'h40);

    // redirect and stall together, unaligned target
    step(0, 0, 0, 1, 1, 32'h103);
    check("lit jal op", 32'(op), 32'h6F);
    check("lit jal PC", PC, 32'h40);
    step(0, 1, 32'h0000_0033, 0, 0, 0);
    check("lit rs addr", imem_addr, 32'h100);

    // PC wraparound at the top of the address space
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 32'h0000_2083, 0, 0, 0);
    check("lit wrap addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    check("lit wrap PC",   PC, 32'hFFFF_FFFC);
    check("lit wrap PC4",  PCPlus4, 32'h0);
    check("lit wrap next", imem_addr, 32'h0);

    // reset while a request waits; its response is ignored
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h7777_7777, 0, 0, 0);
    check("lit rst req", 32'(imem_req), 32'h0);
    step(0, 0, 0, 1, 0, 0);
    check("lit rst valid", 32'(instr_valid), 32'h0);
    check("lit rst addr",  imem_addr, 32'h0);
    check("lit rst instr", instr, NOP);

    // PCSrc and stall ignored while nothing is held
    step(0, 1, 32'h0010_0093, 1, 1, 32'h80);
    check("lit inv req", 32'(imem_req), 32'h1);
    step(0, 0, 0, 0, 0, 0);
    check("lit inv PC",    PC, 32'h0);
    check("lit inv valid", 32'(instr_valid), 32'h1);
    check("lit inv addr",  imem_addr, 32'h4);
    step(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
